intdiv_otf_conv: RTL and testbench

INTDIV_OTF_CONV -- requirements
Module: intdiv_otf_conv

---
 rtl/intdiv_sd2encoding.sv | 22 ++
 rtl/intdiv_otf_cell.sv | 40 ++++
 rtl/intdiv_otf_conv.sv | 122 ++++++++++++
 tb/tb_intdiv_otf_conv.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/intdiv_sd2encoding.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : intdiv_sd2encoding (package)
// Purpose  : Shared radix-2 signed-digit (sd2) encoding for the integer
//            divider. A digit travels as a (p,n) bit pair.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package intdiv_sd2encoding;

  // (p,n) codes: p alone is +1, n alone is -1, equal bits mean zero
  localparam logic [1:0] POS1   = 2'b10;
  localparam logic [1:0] NEG1   = 2'b01;
  localparam logic [1:0] ZERO_1 = 2'b00;
  localparam logic [1:0] ZERO_2 = 2'b11;

  // True when the code carries a zero digit (either zero encoding)
  function automatic logic sd2_is_zero(input logic [1:0] code);
    return (code == ZERO_1) || (code == ZERO_2);
  endfunction

endpackage : intdiv_sd2encoding
`default_nettype wire

// File: rtl/intdiv_otf_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : intdiv_otf_cell
// Purpose  : One on-the-fly conversion step. Appends a signed digit to the
//            pair (Q, QM = Q-1) without a carry-propagating adder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module intdiv_otf_cell
  import intdiv_sd2encoding::*;
#(
  parameter int W = 17
) (
  input  logic [1:0]   digit,
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  // Select the shifted source and appended bit for each digit value
  always_comb begin
    // Zero digit: Q gains a 0, QM gains a 1 (both zero codes land here)
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    case (digit)
      POS1: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
      NEG1: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      default: begin
      end
    endcase
  end

endmodule : intdiv_otf_cell
`default_nettype wire

// File: rtl/intdiv_otf_conv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : intdiv_otf_conv
// Purpose  : Converts N MSB-first sd2 quotient digits into an (N+1)-bit
//            two's-complement quotient using on-the-fly Q/QM conversion.
//            Digits arrive on a valid/ready stream, the result leaves on a
//            valid/ready handshake.
// Options  : INTDIV_OTF_CORR_EN - adds input 'corr'; when set together with
//            the last digit the result is QM (quotient minus one).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module intdiv_otf_conv
  import intdiv_sd2encoding::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [1:0]   din,
`ifdef INTDIV_OTF_CORR_EN
  input  logic         corr,
`endif
  output logic [N:0]   q_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CONV = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [N:0]    r_q;
  logic [N:0]    r_qm;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_result;

  logic [N:0]    w_q_nxt;
  logic [N:0]    w_qm_nxt;
  logic          w_accept;
  logic          w_last;
  logic          w_corr;
  logic          w_zero_digit;

`ifdef INTDIV_OTF_CORR_EN
  assign w_corr = corr;
`else
  assign w_corr = 1'b0;
`endif

  // A digit offered in the same cycle as start belongs to the old operation
  assign w_accept = (r_state == c_CONV) && din_valid && !start;
  assign w_last   = (r_cnt == CW'(N - 1));

  // Status only; the cell decodes both zero codes identically
  assign w_zero_digit = sd2_is_zero(din);

  assign din_ready = (r_state == c_CONV);
  assign out_valid = (r_state == c_DONE);
  assign q_out     = r_result;

  intdiv_otf_cell #(
    .W(N + 1)
  ) u_cell (
    .digit  (din),
    .q      (r_q),
    .qm     (r_qm),
    .q_nxt  (w_q_nxt),
    .qm_nxt (w_qm_nxt)
  );

  // Sequencing: start always wins, otherwise walk IDLE -> CONV -> DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else if (start) begin
      r_state <= c_CONV;
    end else begin
      case (r_state)
        c_IDLE: r_state <= c_IDLE;
        c_CONV: if (w_accept && w_last) r_state <= c_DONE;
        c_DONE: if (out_ready) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Conversion datapath: Q/QM/count advance only on an accepted digit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_qm     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (start) begin
      r_q   <= '0;
      r_qm  <= '1;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_q  <= w_q_nxt;
      r_qm <= w_qm_nxt;
      if (w_last) begin
        r_cnt    <= '0;
        // Correction selects the already-available QM, no subtraction
        r_result <= w_corr ? w_qm_nxt : w_q_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Keep the zero-code decode observable to lint without affecting logic
  logic w_unused;
  assign w_unused = w_zero_digit;

endmodule : intdiv_otf_conv
`default_nettype wire

// File: tb/tb_intdiv_otf_conv.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_intdiv_otf_conv
// Purpose  : Scoreboard bench for intdiv_otf_conv (N=4). Directed operations
//            followed by random digit streams with stalls and output
//            back-pressure; results checked against a digit-sum model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_intdiv_otf_conv;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          din_valid;
  logic          din_ready;
  logic [1:0]    din;
  logic          corr_in;
  logic [NB:0]   q_out;
  logic          out_valid;
  logic          out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  logic [NB:0] exp_q[$];
  logic [NB:0] prev_q;
  bit          have_prev = 1'b0;

  always #5 clk = ~clk;

  intdiv_otf_conv #(
    .N(NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
`ifdef INTDIV_OTF_CORR_EN
    .corr      (corr_in),
`endif
    .q_out     (q_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Quotient value = sum of digit * 2^(weight), wrapped to N+1 bits
  function automatic logic [NB:0] model(input logic [1:0] d[NB], input bit c);
    int v = 0;
    for (int i = 0; i < NB; i++) begin
      v = v * 2;
      if (d[i] == 2'b10) v = v + 1;
      else if (d[i] == 2'b01) v = v - 1;
    end
`ifdef INTDIV_OTF_CORR_EN
    if (c) v = v - 1;
`else
    if (c) v = v + 0;
`endif
    return v[NB:0];
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full operation: digits with stalls, then held result and handoff
  task automatic do_op(input logic [1:0] d[NB], input int gap[NB], input bit c, input int hold);
    pulse_start();
    for (int i = 0; i < NB; i++) begin
      din       = d[i];
      din_valid = 1'b1;
      corr_in   = c;
      if (i == NB - 1) exp_q.push_back(model(d, c));
      check("din_ready_conv", 32'(din_ready), 32'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      din       = 2'($urandom);
      corr_in   = 1'($urandom);
      if (i < NB - 1) begin
        repeat (gap[i]) begin
          check("din_ready_stall", 32'(din_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
    end
    check("out_valid_latency", 32'(out_valid), 32'd1);
    check("din_ready_done", 32'(din_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check("out_valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handoff", 32'(out_valid), 32'd0);
  endtask

  // Monitor: pop on handshake, otherwise the held result must not move
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("result", 32'(q_out), 32'(exp_q.pop_front()));
        end
        have_prev = 1'b0;
      end else begin
        if (have_prev) check("hold_stable", 32'(q_out), 32'(prev_q));
        prev_q    = q_out;
        have_prev = 1'b1;
      end
    end else begin
      have_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [1:0] d[NB];
    int         g[NB];
    rst       = 1'b1;
    start     = 1'b0;
    din_valid = 1'b0;
    din       = 2'b10;
    corr_in   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_din_ready", 32'(din_ready), 32'd0);
    check("reset_q_out", 32'(q_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_din_ready", 32'(din_ready), 32'd0);

    g = '{0, 0, 0, 0};
    // +1,0,-1,+1 -> 7
    d = '{2'b10, 2'b00, 2'b01, 2'b10};
    do_op(d, g, 1'b0, 0);
    // -1 x4 -> -15
    d = '{2'b01, 2'b01, 2'b01, 2'b01};
    do_op(d, g, 1'b0, 0);
    // both zero codes -> 0
    d = '{2'b00, 2'b11, 2'b00, 2'b00};
    do_op(d, g, 1'b0, 0);
    // stall 3 cycles between digits 2 and 3, hold result for 5 cycles
    d = '{2'b10, 2'b00, 2'b01, 2'b10};
    g = '{0, 3, 0, 0};
    do_op(d, g, 1'b0, 5);
    // correction variants of the same digits
    g = '{0, 0, 0, 0};
    do_op(d, g, 1'b1, 0);
    do_op(d, g, 1'b0, 1);

    // abort after two digits, restart with +1 x4 -> 15
    pulse_start();
    din = 2'b01; din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 din_valid = 1'b0;
    d = '{2'b10, 2'b10, 2'b10, 2'b10};
    do_op(d, g, 1'b0, 2);

    // reset after two digits: no result may appear
    pulse_start();
    din = 2'b10; din_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    din = 2'b10; din_valid = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("rst_abort_out_valid", 32'(out_valid), 32'd0);
      check("rst_abort_din_ready", 32'(din_ready), 32'd0);
      check("rst_abort_q_out", 32'(q_out), 32'd0);
    end
    din_valid = 1'b0;

    // start while a result is held in DONE discards it
    d = '{2'b01, 2'b10, 2'b10, 2'b00};
    pulse_start();
    for (int i = 0; i < NB; i++) begin
      din = d[i]; din_valid = 1'b1;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    check("done_before_abort", 32'(out_valid), 32'd1);
    d = '{2'b00, 2'b01, 2'b10, 2'b01};
    do_op(d, g, 1'b0, 0);

    // random operations
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NB; i++) begin
        d[i] = 2'($urandom_range(0, 3));
        g[i] = $urandom_range(0, 2);
      end
      do_op(d, g, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_intdiv_otf_conv
`default_nettype wire
